// File: rtl/mdu_issue_ctrl.sv
// E-stage issue and interlock control in front of the multiply/divide unit.
// Holds the E-stage copy of the MDU opcode and operands and drives the
// one-cycle Start pulse. It stalls the D stage while the MDU is starting or
// busy, counts stall cycles with saturation, and flags a sticky watchdog
// error when Busy stays high too long or a new Start arrives while the
// timer is still running.
module mdu_issue_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_valid,
    input  logic [3:0]       D_MDU_op,
    input  logic [31:0]      D_rs,
    input  logic [31:0]      D_rt,
    input  logic             stall_ext,
    input  logic             flush,
    input  logic             Busy,
    output logic             Start,
    output logic [3:0]       MDU_op,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic             stall_D,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_timeout
);

    localparam int DATA_W = 32;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    // Multi-cycle operations are the only ones that start the MDU engine;
    // moves to/from HI/LO complete without raising Busy.
    function automatic logic is_md(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : (v + one);
    endfunction

    // Watchdog timer increment that stops at the limit.
    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] v);
        return (v < TMR_LIMIT) ? (v + TMR_ONE) : v;
    endfunction

    // E-stage pipeline registers
    logic                     vld_p0;
    logic [3:0]               op_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;

    logic [TMR_W-1:0] tmr_p0;
    logic [TMR_W-1:0] tmr_nxt;
    logic             wd_err_set;
    logic             bubble;

    assign Start   = vld_p0 & is_md(op_p0);
    assign MDU_op  = vld_p0 ? op_p0 : OP_NOP;
    assign A       = a_p0;
    assign B       = b_p0;
    assign stall_D = D_valid & (D_MDU_op != OP_NOP) & (Start | Busy);
    assign bubble  = flush | stall_D | stall_ext;

    // D -> E transfer: flush and stalls insert a bubble, operands hold on a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
            op_p0  <= OP_NOP;
            a_p0   <= '0;
            b_p0   <= '0;
        end else if (bubble) begin
            vld_p0 <= 1'b0;
            op_p0  <= OP_NOP;
        end else begin
            vld_p0 <= D_valid;
            op_p0  <= D_MDU_op;
            a_p0   <= signed'(D_rs);
            b_p0   <= signed'(D_rt);
        end
    end

    // Watchdog next state: arm on Start, count while Busy, clear when idle
    always_comb begin
        tmr_nxt    = tmr_p0;
        wd_err_set = 1'b0;
        if (Start) begin
            tmr_nxt    = TMR_ONE;
            wd_err_set = (tmr_p0 != '0);
        end else if ((tmr_p0 != '0) && Busy) begin
            tmr_nxt = tmr_inc(tmr_p0);
        end else if (!Busy) begin
            tmr_nxt = '0;
        end
        if (tmr_nxt == TMR_LIMIT) begin
            wd_err_set = 1'b1;
        end
    end

    // Watchdog timer and sticky error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmr_p0      <= '0;
            err_timeout <= 1'b0;
        end else begin
            tmr_p0 <= tmr_nxt;
            if (wd_err_set) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // Saturating count of cycles in which the D stage is frozen by the MDU
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_D) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        D_valid = 1'b0;
    logic [3:0]  D_MDU_op = 4'd0;
    logic [31:0] D_rs = 32'd0;
    logic [31:0] D_rt = 32'd0;
    logic        stall_ext = 1'b0;
    logic        flush = 1'b0;
    logic        Busy = 1'b0;

    logic        Start;
    logic [3:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        stall_D;
    logic [31:0] stall_cnt;
    logic        err_timeout;

    logic        s_Start;
    logic [3:0]  s_MDU_op;
    logic [31:0] s_A;
    logic [31:0] s_B;
    logic        s_stall_D;
    logic [1:0]  s_stall_cnt;
    logic        s_err_timeout;

    mdu_issue_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .D_valid(D_valid), .D_MDU_op(D_MDU_op),
        .D_rs(D_rs), .D_rt(D_rt), .stall_ext(stall_ext), .flush(flush),
        .Busy(Busy), .Start(Start), .MDU_op(MDU_op), .A(A), .B(B),
        .stall_D(stall_D), .stall_cnt(stall_cnt), .err_timeout(err_timeout)
    );

    // narrow counter instance so saturation is reachable in a few cycles
    mdu_issue_ctrl #(.TIMEOUT(16), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .D_valid(D_valid), .D_MDU_op(D_MDU_op),
        .D_rs(D_rs), .D_rt(D_rt), .stall_ext(stall_ext), .flush(flush),
        .Busy(Busy), .Start(s_Start), .MDU_op(s_MDU_op), .A(s_A), .B(s_B),
        .stall_D(s_stall_D), .stall_cnt(s_stall_cnt), .err_timeout(s_err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive a D-stage instruction; multi-cycle ops are expected at the MDU port
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        txn_t t;
        D_valid  = 1'b1;
        D_MDU_op = op;
        D_rs     = rs;
        D_rt     = rt;
        if (op >= 4'd1 && op <= 4'd4) begin
            t.op = op;
            t.a  = rs;
            t.b  = rt;
            exp_q.push_back(t);
        end
    endtask

    task automatic do_reset();
        D_valid = 1'b0;
        Busy    = 1'b0;
        reset   = 1'b0;
        tick();
        tick();
        reset   = 1'b1;
    endtask

    // monitor: every Start pulse must match the oldest issued MDU op
    initial begin
        bit   prev;
        txn_t t;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && reset === 1'b1) begin
                if (Start === 1'b1) begin
                    chk("start_one_cycle", {31'd0, prev}, 32'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL start_unexpected: got Start=1 op=%0d expected no pending op", MDU_op);
                    end else begin
                        t = exp_q.pop_front();
                        chk("start_op", {28'd0, MDU_op}, {28'd0, t.op});
                        chk("start_a", A, t.a);
                        chk("start_b", B, t.b);
                    end
                end
                prev = (Start === 1'b1);
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // reset with random D-stage activity
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            D_valid  = 1'b1;
            D_MDU_op = 4'($urandom_range(1, 8));
            D_rs     = $urandom;
            D_rt     = $urandom;
            tick();
        end
        #1;
        chk("rst_start", {31'd0, Start}, 32'd0);
        chk("rst_stall_d", {31'd0, stall_D}, 32'd0);
        chk("rst_mdu_op", {28'd0, MDU_op}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        D_valid = 1'b0;
        reset   = 1'b1;
        mon_en  = 1'b1;
        tick();

        // single mult: 7 * -3
        issue(4'd1, 32'd7, 32'hFFFF_FFFD);
        tick();
        D_valid = 1'b0;
        #1;
        chk("mult_start", {31'd0, Start}, 32'd1);
        chk("mult_a", A, 32'd7);
        chk("mult_b", B, 32'hFFFF_FFFD);
        tick();
        #1;
        chk("mult_start_drop", {31'd0, Start}, 32'd0);

        // mult then mflo, Busy for 5 cycles
        issue(4'd1, 32'd12, 32'd5);
        tick();
        D_valid  = 1'b1;
        D_MDU_op = 4'd6;
        #1;
        chk("il_stall_start", {31'd0, stall_D}, 32'd1);
        tick();
        Busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("il_stall_busy", {31'd0, stall_D}, 32'd1);
            tick();
        end
        Busy = 1'b0;
        #1;
        chk("il_stall_release", {31'd0, stall_D}, 32'd0);
        chk("il_e_bubble", {28'd0, MDU_op}, 32'd0);
        tick();
        D_valid = 1'b0;
        #1;
        chk("il_mflo_in_e", {28'd0, MDU_op}, 32'd6);
        chk("il_cnt", stall_cnt, 32'd6);
        chk("il_sat_cnt", {30'd0, s_stall_cnt}, 32'd3);

        // div then mthi, Busy for 10 cycles
        do_reset();
        #1;
        chk("rst2_cnt", stall_cnt, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        tick();
        D_valid  = 1'b1;
        D_MDU_op = 4'd7;
        D_rs     = 32'h55;
        D_rt     = 32'd0;
        tick();
        Busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("dv_stall_busy", {31'd0, stall_D}, 32'd1);
            tick();
        end
        Busy = 1'b0;
        #1;
        chk("dv_stall_release", {31'd0, stall_D}, 32'd0);
        tick();
        D_valid = 1'b0;
        #1;
        chk("dv_mthi_in_e", {28'd0, MDU_op}, 32'd7);
        chk("dv_mthi_a", A, 32'h55);
        chk("dv_no_start", {31'd0, Start}, 32'd0);
        chk("dv_cnt", stall_cnt, 32'd11);

        // flush together with stall_ext on a D-stage div
        D_valid   = 1'b1;
        D_MDU_op  = 4'd3;
        D_rs      = 32'd9;
        D_rt      = 32'd2;
        flush     = 1'b1;
        stall_ext = 1'b1;
        #1;
        chk("fl_stall_d", {31'd0, stall_D}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_start", {31'd0, Start}, 32'd0);
        chk("fl_mdu_op", {28'd0, MDU_op}, 32'd0);
        chk("fl_cnt", stall_cnt, 32'd11);
        tick();
        #1;
        chk("ext_start", {31'd0, Start}, 32'd0);
        chk("ext_cnt", stall_cnt, 32'd11);
        stall_ext = 1'b0;
        issue(4'd3, 32'd9, 32'd2);
        tick();
        D_valid = 1'b0;
        #1;
        chk("ext_release_start", {31'd0, Start}, 32'd1);
        tick();

        // flush in the Start cycle clears E only
        issue(4'd2, 32'hFFFF_0000, 32'd3);
        tick();
        D_valid = 1'b0;
        flush   = 1'b1;
        #1;
        chk("fs_start", {31'd0, Start}, 32'd1);
        tick();
        flush = 1'b0;
        #1;
        chk("fs_cleared", {28'd0, MDU_op}, 32'd0);

        // watchdog: Busy held after Start
        do_reset();
        issue(4'd4, 32'd50, 32'd5);
        tick();
        D_valid = 1'b0;
        tick();
        Busy = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        #1;
        chk("wd_err_before", {31'd0, err_timeout}, 32'd0);
        tick();
        #1;
        chk("wd_err_at_limit", {31'd0, err_timeout}, 32'd1);
        D_valid  = 1'b1;
        D_MDU_op = 4'd0;
        #1;
        chk("wd_nop_no_stall", {31'd0, stall_D}, 32'd0);
        D_MDU_op = 4'd5;
        #1;
        chk("wd_mfhi_stall", {31'd0, stall_D}, 32'd1);
        D_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Busy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #1;
        chk("wd_err_sticky", {31'd0, err_timeout}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("wd_err_cleared", {31'd0, err_timeout}, 32'd0);

        // saturation of the narrow counter
        do_reset();
        Busy     = 1'b1;
        D_valid  = 1'b1;
        D_MDU_op = 4'd5;
        for (int i = 0; i < 5; i++) tick();
        Busy    = 1'b0;
        D_valid = 1'b0;
        #1;
        chk("sat_cnt", {30'd0, s_stall_cnt}, 32'd3);
        chk("sat_wide_cnt", stall_cnt, 32'd5);
        chk("sat_no_err", {31'd0, err_timeout}, 32'd0);

        for (int i = 0; i < 3; i++) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- E-stage issue/interlock block placed directly upstream of the multiply/divide unit.
- Holds the E-stage copy of the MDU opcode and operands, and drives the one-cycle Start pulse, MDU_op, A and B into the MDU.
- Raises the D-stage stall while the MDU is starting or busy.
- Also keeps a saturating stall-cycle counter and a sticky watchdog error when Busy never falls.

Parameters:
- TIMEOUT, 16: max cycles Busy may stay high after Start before err_timeout sets.
- CNT_W, 32: width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- D_valid  input  1  D-stage instruction is valid.
- D_MDU_op  input  4  D-stage MDU opcode: nop=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8.
- D_rs  input  32  forwarded rs value in D.
- D_rt  input  32  forwarded rt value in D.
- stall_ext  input  1  stall from the data-hazard unit; bubble into E.
- flush  input  1  clear E-stage MDU register.
- Busy  input  1  MDU busy flag.
- Start  output  1  to MDU.
- MDU_op  output  4  to MDU (E register).
- A  output  32  to MDU (E register).
- B  output  32  to MDU (E register).
- stall_D  output  1  freeze PC/D, bubble E.
- stall_cnt  output  CNT_W  cycles with stall_D=1.
- err_timeout  output  1  sticky watchdog error.

Behaviour:
- Reset (reset==0 at the edge):
  - E_valid=0; MDU_op=0; A=0; B=0.
  - stall_cnt=0; err_timeout=0; watchdog timer=0.
  - Start=0 and stall_D=0 follow combinationally.
  - Reset mid-operation discards the in-flight instruction. The MDU receives its own reset from the top level.
- Combinational outputs:
  - is_md(op) = op in {1,2,3,4}.
  - Start = E_valid & is_md(MDU_op).
  - stall_D = D_valid & (D_MDU_op != 0) & (Start | Busy).
  - MDU_op output is forced to 0 when E_valid=0.
- E register update on each clk edge (reset deasserted), in priority order:
  1. flush -> E_valid=0, op=0.
  2. stall_D | stall_ext -> bubble (E_valid=0, op=0); A and B may hold.
  3. Otherwise E_valid<=D_valid, MDU_op<=D_MDU_op, A<=D_rs, B<=D_rt.
- Start is therefore exactly one cycle wide per instruction. A stalled D instruction enters E only after Start=0 and Busy=0.
- mthi/mtlo in E with Busy=0: the MDU writes at that edge. mfhi/mflo directly behind it needs no stall.
- stall_cnt increments by 1 on every edge where stall_D=1 and saturates at all-ones (no wrap). stall_ext alone does not count.
- Watchdog:
  - Timer loads 1 when Start=1.
  - While the timer is non-zero and Busy=1, it increments.
  - Clears when Busy=0 and Start=0.
  - If the timer reaches TIMEOUT, err_timeout<=1 and stays set until reset.
  - A new Start while the timer is non-zero also sets err_timeout (issue while busy is illegal).
- Simultaneous events:
  - flush together with stall: flush wins.
  - flush in the Start cycle: Start has already been seen by the MDU; the flush only clears E.
  - Busy falling in the same cycle a D-stage MDU op waits: stall_D=0 that cycle, and the op enters E at the edge.

Test Plan:
- Reset: hold reset=0 for 2 clk with random D inputs -> Start=0, stall_D=0, stall_cnt=0, err_timeout=0, MDU_op=0.
- Issue mult: D_MDU_op=1, D_rs=7, D_rt=-3 -> next cycle Start=1 for exactly 1 cycle, A=7, B=0xFFFFFFFD, MDU_op=1.
- Interlock: mult followed by mflo in D; Busy high for 5 cycles after Start -> stall_D=1 for 6 cycles (Start cycle + 5 Busy), mflo enters E the cycle after Busy falls, stall_cnt=6.
- div then mthi back-to-back: Busy high 10 cycles -> mthi held in D, stall_cnt=11; an unrelated D op (D_MDU_op=0) during Busy -> stall_D=0.
- Flush/priority: flush=1 together with stall_ext=1 on a D-stage div -> E bubble, Start stays 0, no counter change.
- Watchdog: Start then hold Busy=1 for 20 cycles -> err_timeout=1 at timer=16 and stays 1 until reset=0. Separately, preload stall_cnt near all-ones and stall 3 cycles -> stall_cnt stays 0xFFFFFFFF.
